// File: rtl/sys_ctrl.sv
// Command sequencer: decodes framed UART byte commands into register-file
// accesses and ALU operations, and returns read data / ALU results to the TX FIFO.
module sys_ctrl #(
    parameter int DATA_W = 8,
    parameter int ADDR_W = 4,
    parameter int ALU_W  = 2 * DATA_W
) (
    input  logic              Clk,
    input  logic              Rst,
    input  logic [DATA_W-1:0] RX_P_DATA,
    input  logic              RX_D_VLD,
    input  logic [DATA_W-1:0] RdData,
    input  logic              Rd_dataValid,
    input  logic [ALU_W-1:0]  ALU_OUT,
    input  logic              ALU_OUT_Valid,
    input  logic              FIFO_FULL,
    output logic              WrEn,
    output logic              RdEn,
    output logic [ADDR_W-1:0] Address,
    output logic [DATA_W-1:0] WrData,
    output logic              ALU_EN,
    output logic [3:0]        ALU_FUN,
    output logic              CLK_GATE_EN,
    output logic [DATA_W-1:0] TX_P_DATA,
    output logic              TX_D_VLD
);

    localparam logic [DATA_W-1:0] CMD_WR     = DATA_W'(8'hAA);
    localparam logic [DATA_W-1:0] CMD_RD     = DATA_W'(8'hBB);
    localparam logic [DATA_W-1:0] CMD_ALU_OP = DATA_W'(8'hCC);
    localparam logic [DATA_W-1:0] CMD_ALU_NO = DATA_W'(8'hDD);

    typedef enum logic [3:0] {
        S_IDLE, S_WR_ADDR, S_WR_DATA, S_RD_ADDR, S_RD_WAIT, S_RD_SEND,
        S_ALU_A, S_ALU_B, S_ALU_FUN, S_ALU_WAIT, S_TX_LO, S_TX_HI
    } state_t;

    state_t              state_q;
    logic [ADDR_W-1:0]   addr_q;
    logic [DATA_W-1:0]   rd_q;
    logic [ALU_W-1:0]    alu_q;

    always_ff @(posedge Clk or negedge Rst) begin
        if (!Rst) begin
            state_q     <= S_IDLE;
            addr_q      <= '0;
            rd_q        <= '0;
            alu_q       <= '0;
            WrEn        <= 1'b0;
            RdEn        <= 1'b0;
            Address     <= '0;
            WrData      <= '0;
            ALU_EN      <= 1'b0;
            ALU_FUN     <= '0;
            CLK_GATE_EN <= 1'b0;
            TX_P_DATA   <= '0;
            TX_D_VLD    <= 1'b0;
        end else begin
            // NOTE: strobes default low every cycle so each assertion below is a single-cycle pulse.
            WrEn     <= 1'b0;
            RdEn     <= 1'b0;
            ALU_EN   <= 1'b0;
            TX_D_VLD <= 1'b0;

            case (state_q)
                S_IDLE: begin
                    if (RX_D_VLD) begin
                        case (RX_P_DATA)
                            CMD_WR:     state_q <= S_WR_ADDR;
                            CMD_RD:     state_q <= S_RD_ADDR;
                            CMD_ALU_OP: state_q <= S_ALU_A;
                            CMD_ALU_NO: state_q <= S_ALU_FUN;
                            default:    state_q <= S_IDLE;
                        endcase
                    end
                end
                S_WR_ADDR: begin
                    if (RX_D_VLD) begin
                        addr_q  <= RX_P_DATA[ADDR_W-1:0];
                        state_q <= S_WR_DATA;
                    end
                end
                S_WR_DATA: begin
                    if (RX_D_VLD) begin
                        WrEn    <= 1'b1;
                        Address <= addr_q;
                        WrData  <= RX_P_DATA;
                        state_q <= S_IDLE;
                    end
                end
                S_RD_ADDR: begin
                    if (RX_D_VLD) begin
                        RdEn    <= 1'b1;
                        Address <= RX_P_DATA[ADDR_W-1:0];
                        state_q <= S_RD_WAIT;
                    end
                end
                S_RD_WAIT: begin
                    if (Rd_dataValid) begin
                        rd_q    <= RdData;
                        state_q <= S_RD_SEND;
                    end
                end
                S_RD_SEND: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= rd_q;
                        state_q   <= S_IDLE;
                    end
                end
                // Operands land in REG0/REG1, where the ALU reads them.
                S_ALU_A: begin
                    if (RX_D_VLD) begin
                        WrEn    <= 1'b1;
                        Address <= '0;
                        WrData  <= RX_P_DATA;
                        state_q <= S_ALU_B;
                    end
                end
                S_ALU_B: begin
                    if (RX_D_VLD) begin
                        WrEn    <= 1'b1;
                        Address <= ADDR_W'(1);
                        WrData  <= RX_P_DATA;
                        state_q <= S_ALU_FUN;
                    end
                end
                S_ALU_FUN: begin
                    if (RX_D_VLD) begin
                        ALU_EN      <= 1'b1;
                        ALU_FUN     <= RX_P_DATA[3:0];
                        CLK_GATE_EN <= 1'b1;
                        state_q     <= S_ALU_WAIT;
                    end
                end
                S_ALU_WAIT: begin
                    if (ALU_OUT_Valid) begin
                        alu_q       <= ALU_OUT;
                        CLK_GATE_EN <= 1'b0;
                        state_q     <= S_TX_LO;
                    end
                end
                S_TX_LO: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= alu_q[DATA_W-1:0];
                        state_q   <= S_TX_HI;
                    end
                end
                S_TX_HI: begin
                    if (!FIFO_FULL) begin
                        TX_D_VLD  <= 1'b1;
                        TX_P_DATA <= alu_q[DATA_W +: DATA_W];
                        state_q   <= S_IDLE;
                    end
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_sys_ctrl.sv
// Directed bench for sys_ctrl: write, read, ALU frames, FIFO back-pressure,
// junk-byte rejection and mid-frame reset.
module tb_sys_ctrl;

    logic        Clk = 1'b0;
    logic        Rst = 1'b0;
    logic [7:0]  RX_P_DATA = '0;
    logic        RX_D_VLD = 1'b0;
    logic [7:0]  RdData = '0;
    logic        Rd_dataValid = 1'b0;
    logic [15:0] ALU_OUT = '0;
    logic        ALU_OUT_Valid = 1'b0;
    logic        FIFO_FULL = 1'b0;
    logic        WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD;
    logic [3:0]  Address, ALU_FUN;
    logic [7:0]  WrData, TX_P_DATA;

    int total = 0;
    int bad   = 0;

    int        wr_cnt = 0;
    int        rd_cnt = 0;
    int        both_cnt = 0;
    logic [7:0] tx_log[$];

    sys_ctrl dut (
        .Clk(Clk), .Rst(Rst),
        .RX_P_DATA(RX_P_DATA), .RX_D_VLD(RX_D_VLD),
        .RdData(RdData), .Rd_dataValid(Rd_dataValid),
        .ALU_OUT(ALU_OUT), .ALU_OUT_Valid(ALU_OUT_Valid),
        .FIFO_FULL(FIFO_FULL),
        .WrEn(WrEn), .RdEn(RdEn), .Address(Address), .WrData(WrData),
        .ALU_EN(ALU_EN), .ALU_FUN(ALU_FUN), .CLK_GATE_EN(CLK_GATE_EN),
        .TX_P_DATA(TX_P_DATA), .TX_D_VLD(TX_D_VLD)
    );

    always #5 Clk = ~Clk;

    initial begin
        #200000;
        $display("FAIL watchdog expired");
        $fatal(1, "watchdog");
    end

    // Pulse and push monitor, sampled mid-cycle.
    always @(negedge Clk) begin
        if (WrEn) wr_cnt++;
        if (RdEn) rd_cnt++;
        if (WrEn && RdEn) both_cnt++;
        if (TX_D_VLD) tx_log.push_back(TX_P_DATA);
    end

    // Present one byte for exactly one posedge; returns at the negedge after it.
    task automatic send_byte(input logic [7:0] b);
        @(negedge Clk);
        RX_P_DATA = b;
        RX_D_VLD  = 1'b1;
        @(negedge Clk);
        RX_D_VLD  = 1'b0;
    endtask

    task automatic idle(input int n);
        repeat (n) @(negedge Clk);
    endtask

    task automatic test_reset;
        Rst = 1'b0;
        #3;
        total++;
        if ({WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD} !== 5'b0) begin
            bad++; $display("FAIL reset_strobes act=%b exp=0", {WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD});
        end
        total++;
        if ({Address, ALU_FUN, WrData, TX_P_DATA} !== 24'h0) begin
            bad++; $display("FAIL reset_buses act=%h exp=0", {Address, ALU_FUN, WrData, TX_P_DATA});
        end
        @(negedge Clk);
        Rst = 1'b1;
        idle(2);
    endtask

    task automatic test_write;
        int wr0 = wr_cnt;
        int rd0 = rd_cnt;
        send_byte(8'hAA);
        send_byte(8'h05);
        total++;
        if (WrEn !== 1'b0) begin bad++; $display("FAIL wr_early act=%b exp=0", WrEn); end
        send_byte(8'h3C);
        total++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h5, 8'h3C}) begin
            bad++; $display("FAIL wr_pulse act=%b/%h/%h exp=1/5/3c", WrEn, Address, WrData);
        end
        @(negedge Clk);
        total++;
        if (WrEn !== 1'b0) begin bad++; $display("FAIL wr_one_cycle act=%b exp=0", WrEn); end
        total++;
        if ({Address, WrData} !== {4'h5, 8'h3C}) begin
            bad++; $display("FAIL wr_hold act=%h/%h exp=5/3c", Address, WrData);
        end
        idle(3);
        total++;
        if (wr_cnt - wr0 !== 1 || rd_cnt - rd0 !== 0) begin
            bad++; $display("FAIL wr_counts act=wr%0d rd%0d exp=wr1 rd0", wr_cnt - wr0, rd_cnt - rd0);
        end
    endtask

    task automatic test_read;
        int rd0 = rd_cnt;
        int tx0 = tx_log.size();
        send_byte(8'hBB);
        send_byte(8'hF5);  // upper nibble must be ignored
        total++;
        if ({RdEn, WrEn, Address} !== {1'b1, 1'b0, 4'h5}) begin
            bad++; $display("FAIL rd_pulse act=%b/%b/%h exp=1/0/5", RdEn, WrEn, Address);
        end
        @(negedge Clk);
        total++;
        if (RdEn !== 1'b0) begin bad++; $display("FAIL rd_one_cycle act=%b exp=0", RdEn); end
        idle(2);
        RdData = 8'h3C;
        Rd_dataValid = 1'b1;
        @(negedge Clk);             // edge r has passed
        Rd_dataValid = 1'b0;
        RdData = 8'h00;
        total++;
        if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL rd_tx_early act=%b exp=0", TX_D_VLD); end
        @(negedge Clk);             // cycle r+2
        total++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h3C}) begin
            bad++; $display("FAIL rd_tx act=%b/%h exp=1/3c", TX_D_VLD, TX_P_DATA);
        end
        idle(3);
        total++;
        if (tx_log.size() - tx0 !== 1 || rd_cnt - rd0 !== 1) begin
            bad++; $display("FAIL rd_counts act=tx%0d rd%0d exp=tx1 rd1", tx_log.size() - tx0, rd_cnt - rd0);
        end
    endtask

    task automatic test_alu_operands;
        send_byte(8'hCC);
        send_byte(8'h07);
        total++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h0, 8'h07}) begin
            bad++; $display("FAIL alu_opa act=%b/%h/%h exp=1/0/07", WrEn, Address, WrData);
        end
        send_byte(8'h03);
        total++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h1, 8'h03}) begin
            bad++; $display("FAIL alu_opb act=%b/%h/%h exp=1/1/03", WrEn, Address, WrData);
        end
        send_byte(8'h00);
        total++;
        if ({ALU_EN, ALU_FUN, CLK_GATE_EN} !== {1'b1, 4'h0, 1'b1}) begin
            bad++; $display("FAIL alu_en act=%b/%h/%b exp=1/0/1", ALU_EN, ALU_FUN, CLK_GATE_EN);
        end
        send_byte(8'h77);           // dropped while waiting on the ALU
        total++;
        if ({ALU_EN, CLK_GATE_EN, WrEn} !== 3'b010) begin
            bad++; $display("FAIL alu_wait act=%b exp=010", {ALU_EN, CLK_GATE_EN, WrEn});
        end
        ALU_OUT = 16'h000A;
        ALU_OUT_Valid = 1'b1;
        @(negedge Clk);             // edge v passed
        ALU_OUT_Valid = 1'b0;
        ALU_OUT = 16'hFFFF;
        total++;
        if ({CLK_GATE_EN, TX_D_VLD} !== 2'b00) begin
            bad++; $display("FAIL alu_gate_off act=%b exp=00", {CLK_GATE_EN, TX_D_VLD});
        end
        @(negedge Clk);
        total++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h0A}) begin
            bad++; $display("FAIL alu_tx_lo act=%b/%h exp=1/0a", TX_D_VLD, TX_P_DATA);
        end
        @(negedge Clk);
        total++;
        if ({TX_D_VLD, TX_P_DATA} !== {1'b1, 8'h00}) begin
            bad++; $display("FAIL alu_tx_hi act=%b/%h exp=1/00", TX_D_VLD, TX_P_DATA);
        end
        @(negedge Clk);
        total++;
        if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL alu_tx_end act=%b exp=0", TX_D_VLD); end
    endtask

    task automatic test_alu_fifo_full;
        int tx0 = tx_log.size();
        FIFO_FULL = 1'b1;
        send_byte(8'hDD);
        send_byte(8'h52);
        total++;
        if ({ALU_EN, ALU_FUN, CLK_GATE_EN, WrEn} !== {1'b1, 4'h2, 1'b1, 1'b0}) begin
            bad++; $display("FAIL full_alu_en act=%b/%h/%b/%b exp=1/2/1/0", ALU_EN, ALU_FUN, CLK_GATE_EN, WrEn);
        end
        idle(1);
        ALU_OUT = 16'h1234;
        ALU_OUT_Valid = 1'b1;
        @(negedge Clk);
        ALU_OUT_Valid = 1'b0;
        ALU_OUT = 16'h0000;
        for (int i = 0; i < 5; i++) begin
            total++;
            if (TX_D_VLD !== 1'b0) begin bad++; $display("FAIL full_no_push[%0d] act=%b exp=0", i, TX_D_VLD); end
            @(negedge Clk);
        end
        FIFO_FULL = 1'b0;
        idle(4);
        total++;
        if (tx_log.size() - tx0 !== 2) begin
            bad++; $display("FAIL full_push_count act=%0d exp=2", tx_log.size() - tx0);
        end else begin
            total++;
            if ({tx_log[tx0], tx_log[tx0+1]} !== 16'h3412) begin
                bad++; $display("FAIL full_push_order act=%h %h exp=34 12", tx_log[tx0], tx_log[tx0+1]);
            end
        end
        total++;
        if (ALU_FUN !== 4'h2) begin bad++; $display("FAIL fun_hold act=%h exp=2", ALU_FUN); end
    endtask

    task automatic test_ignore_junk;
        int wr0 = wr_cnt;
        send_byte(8'h55);
        send_byte(8'hAA);
        send_byte(8'h01);
        send_byte(8'h11);
        total++;
        if ({WrEn, Address, WrData} !== {1'b1, 4'h1, 8'h11}) begin
            bad++; $display("FAIL junk_wr act=%b/%h/%h exp=1/1/11", WrEn, Address, WrData);
        end
        idle(3);
        total++;
        if (wr_cnt - wr0 !== 1) begin bad++; $display("FAIL junk_count act=%0d exp=1", wr_cnt - wr0); end
    endtask

    task automatic test_reset_midframe;
        int wr0;
        send_byte(8'hAA);
        send_byte(8'h02);
        #2;
        Rst = 1'b0;
        #1;
        total++;
        if ({WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, Address, ALU_FUN, WrData, TX_P_DATA} !== 29'h0) begin
            bad++; $display("FAIL async_reset act=%h exp=0",
                {WrEn, RdEn, ALU_EN, CLK_GATE_EN, TX_D_VLD, Address, ALU_FUN, WrData, TX_P_DATA});
        end
        @(negedge Clk);
        Rst = 1'b1;
        wr0 = wr_cnt;
        send_byte(8'h02);
        idle(3);
        total++;
        if (wr_cnt - wr0 !== 0 || WrData !== 8'h00) begin
            bad++; $display("FAIL reset_discard act=wr%0d data%h exp=wr0 data00", wr_cnt - wr0, WrData);
        end
    endtask

    initial begin
        test_reset();
        test_write();
        test_read();
        test_alu_operands();
        test_alu_fifo_full();
        test_ignore_junk();
        test_reset_midframe();
        total++;
        if (both_cnt !== 0) begin bad++; $display("FAIL wr_rd_overlap act=%0d exp=0", both_cnt); end
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/sys_ctrl.md
# sys_ctrl

Command sequencer between the UART receive path and the register file/ALU. Decodes framed byte commands arriving on a single-cycle-valid byte stream, drives register-file read/write strobes and ALU enable/function, and returns read data or ALU results to the transmit FIFO. The block is the only master of the register file and the ALU clock gate in the system clock domain.

## Interface
- DATA_W, 8, byte/register width
- ADDR_W, 4, register-file address width
- ALU_W, 16, ALU result width (2*DATA_W)

- Clk  in  1  system clock
- Rst  in  1  asynchronous active-low reset
- RX_P_DATA  in  DATA_W  received byte
- RX_D_VLD  in  1  one-cycle pulse per received byte
- RdData  in  DATA_W  register-file read data
- Rd_dataValid  in  1  register-file read data valid
- ALU_OUT  in  ALU_W  ALU result
- ALU_OUT_Valid  in  1  ALU result valid
- FIFO_FULL  in  1  TX FIFO full; no push while high
- WrEn / RdEn  out  1  register-file strobes, one-cycle pulses
- Address  out  ADDR_W  register-file address
- WrData  out  DATA_W  register-file write data
- ALU_EN  out  1  ALU operation enable
- ALU_FUN  out  4  ALU function code
- CLK_GATE_EN  out  1  ALU clock-gate enable
- TX_P_DATA  out  DATA_W  byte pushed to TX FIFO
- TX_D_VLD  out  1  one-cycle push strobe

## Operation
- Frames: 0xAA addr data = write; 0xBB addr = read; 0xCC opA opB fun = ALU with operands; 0xDD fun = ALU on current REG0/REG1.
- Address taken from RX_P_DATA[ADDR_W-1:0]; upper bits ignored. Function from RX_P_DATA[3:0].
- States: IDLE, WR_ADDR, WR_DATA, RD_ADDR, RD_WAIT, RD_SEND, ALU_A, ALU_B, ALU_FUN, ALU_WAIT, TX_LO, TX_HI.
- IDLE: on command byte go to WR_ADDR / RD_ADDR / ALU_A / ALU_FUN; any other byte dropped, stay IDLE.
- WR_ADDR: latch address -> WR_DATA. WR_DATA: on byte pulse WrEn with Address/WrData -> IDLE.
- RD_ADDR: on byte pulse RdEn -> RD_WAIT. RD_WAIT: on Rd_dataValid capture RdData -> RD_SEND. RD_SEND: when !FIFO_FULL push captured byte -> IDLE.
- ALU_A: on byte write it to address 0 -> ALU_B. ALU_B: write byte to address 1 -> ALU_FUN.
- ALU_FUN: on byte assert ALU_EN with ALU_FUN, set CLK_GATE_EN -> ALU_WAIT. ALU_WAIT: on ALU_OUT_Valid capture ALU_OUT, clear CLK_GATE_EN -> TX_LO. TX_LO: push ALU_OUT[7:0] when !FIFO_FULL -> TX_HI. TX_HI: push ALU_OUT[15:8] when !FIFO_FULL -> IDLE.
- RX_D_VLD in RD_WAIT, RD_SEND, ALU_WAIT, TX_LO, TX_HI: byte dropped, no state effect.
- WrEn and RdEn never high together; never push while FIFO_FULL.

## Timing
- All outputs registered. Reset value of every output 0; state IDLE; capture registers 0.
- Byte sampled at edge t (RX_D_VLD=1) -> resulting WrEn/RdEn/ALU_EN pulse high during cycle t+1, exactly one cycle.
- Address/WrData valid in the same cycle as WrEn/RdEn; hold last value otherwise.
- ALU_EN is one-cycle pulse; ALU_FUN holds until next ALU command. CLK_GATE_EN high from cycle t+1 of function byte through cycle ALU_OUT_Valid is sampled, low the cycle after.
- Rd_dataValid sampled at edge r -> TX_D_VLD high in cycle r+2 if FIFO_FULL low at edge r+1; otherwise first cycle after FIFO_FULL sampled low.
- TX_LO and TX_HI pushes separated by at least one cycle-boundary; back-to-back pushes permitted when FIFO_FULL low.
- Async reset at any point: state to IDLE, all outputs 0 immediately, partial frame discarded.

## Test plan
- Bytes 0xAA,0x05,0x3C -> single WrEn pulse, Address=5, WrData=0x3C; RdEn stays 0.
- Bytes 0xBB,0x05; model returns RdData=0x3C with Rd_dataValid -> one RdEn pulse Address=5, then one TX_D_VLD with TX_P_DATA=0x3C.
- Bytes 0xCC,0x07,0x03,0x00; ALU returns 0x000A -> WrEn addr 0 data 0x07, WrEn addr 1 data 0x03, ALU_EN pulse ALU_FUN=0, CLK_GATE_EN high until valid, TX bytes 0x0A then 0x00.
- 0xDD,0x02 with FIFO_FULL high 5 cycles after ALU_OUT_Valid (0x1234) -> no TX_D_VLD while full, then 0x34 then 0x12.
- Byte 0x55 in IDLE, then 0xAA,0x01,0x11 -> 0x55 ignored, single write addr 1 data 0x11.
- Rst low after 0xAA,0x02 -> all outputs 0; following 0x02 byte ignored (IDLE), no WrEn.
